exp_ker_rd_ctrl: RTL and testbench

Parametrised kernel-RAM read controller for the expand stage, serving both 1x1 and 3x3 expand kernels. It sequences read addresses through a fire layer's kernel memory one input-depth slice at a time, and replays each slice once per output row group. Each slice is read only after the write controller reports that slice as written. It sits between the expand kernel RAM and the expand MAC array, using a req/ready word handshake.

---
 rtl/exp_ker_rd_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_exp_ker_rd_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_ker_rd_ctrl.sv
// Kernel-RAM read controller for the expand stage: walks depth slices, replays each
// slice dim+1 times, and holds off a slice until the write side reports it complete.
module exp_ker_rd_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int KW_W    = 7,
    parameter int DEPTH_W = 6,
    parameter int DIM_W   = 7,
    parameter int RD_LAT  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               mode_3x3_i,
    input  logic [KW_W-1:0]    ker_words_i,
    input  logic [DEPTH_W-1:0] depth_i,
    input  logic [DIM_W-1:0]   dim_i,
    input  logic               bypass_i,
    input  logic [DEPTH_W:0]   wr_layer_cnt_i,
    input  logic               ker_req_i,
    output logic               ker_ready_o,
    output logic               ram_rd_en_o,
    output logic [ADDR_W-1:0]  ram_rd_addr_o,
    output logic               ker_valid_o,
    output logic               ker_first_o,
    output logic               ker_last_o,
    output logic [DEPTH_W:0]   rd_layers_done_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int LEN_W = 11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [DIM_W-1:0]     dim_q, dim_d;
    logic                 bypass_q, bypass_d;
    logic [LEN_W-1:0]     w_q, w_d;
    logic [DIM_W-1:0]     r_q, r_d;
    logic [DEPTH_W-1:0]   d_q, d_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DEPTH_W:0]     layers_q, layers_d;
    logic [RD_LAT-1:0]    vld_q, vld_d;
    logic [RD_LAT-1:0]    first_q, first_d;
    logic [RD_LAT-1:0]    last_q, last_d;
    logic [RD_LAT-1:0]    fin_q, fin_d;

    logic [LEN_W-1:0]     kw_ext;
    logic [LEN_W-1:0]     len_calc;
    logic                 start_go;
    logic                 accept;
    logic                 w_last;
    logic                 r_last;
    logic                 d_last;
    logic                 final_word;

    // Nine taps per kernel in 3x3 mode: kw*9 = (kw << 3) + kw.
    assign kw_ext   = LEN_W'(ker_words_i);
    assign len_calc = mode_3x3_i ? ((kw_ext << 3) + kw_ext) : kw_ext;

    assign start_go   = start_i && (ker_words_i != '0);
    assign w_last     = (w_q == (len_q - LEN_W'(1)));
    assign r_last     = (r_q == dim_q);
    assign d_last     = (d_q == depth_q);
    assign final_word = w_last && r_last && d_last;

    assign ker_ready_o = (state_q == S_RUN) &&
                         (bypass_q || ({1'b0, d_q} < wr_layer_cnt_i));
    // A restart in the same cycle wins, so the word offered there is not taken.
    assign accept      = ker_req_i && ker_ready_o && !start_go;
    assign ram_rd_en_o = accept;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d  = state_q;
        len_d    = len_q;
        depth_d  = depth_q;
        dim_d    = dim_q;
        bypass_d = bypass_q;
        w_d      = w_q;
        r_d      = r_q;
        d_d      = d_q;
        base_d   = base_q;
        layers_d = layers_q;

        vld_d[0]   = accept;
        first_d[0] = accept && (w_q == '0);
        last_d[0]  = accept && w_last;
        fin_d[0]   = accept && final_word;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]   = vld_q[i-1];
            first_d[i] = first_q[i-1];
            last_d[i]  = last_q[i-1];
            fin_d[i]   = fin_q[i-1];
        end

        if (start_go) begin
            state_d  = S_RUN;
            len_d    = len_calc;
            depth_d  = depth_i;
            dim_d    = dim_i;
            bypass_d = bypass_i;
            w_d      = '0;
            r_d      = '0;
            d_d      = '0;
            base_d   = '0;
            layers_d = '0;
            vld_d    = '0;
            first_d  = '0;
            last_d   = '0;
            fin_d    = '0;
        end else if (accept) begin
            if (w_last) begin
                w_d = '0;
                if (r_last) begin
                    r_d      = '0;
                    d_d      = d_q + DEPTH_W'(1);
                    base_d   = base_q + ADDR_W'(len_q);
                    layers_d = layers_q + (DEPTH_W+1)'(1);
                end else begin
                    r_d = r_q + DIM_W'(1);
                end
            end else begin
                w_d = w_q + LEN_W'(1);
            end
            if (final_word) begin
                state_d = S_IDLE;
            end
        end

        // Address register always tracks base+w, so it is ready before the accept.
        addr_d = base_d + ADDR_W'(w_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            depth_q  <= '0;
            dim_q    <= '0;
            bypass_q <= 1'b0;
            w_q      <= '0;
            r_q      <= '0;
            d_q      <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            layers_q <= '0;
            vld_q    <= '0;
            first_q  <= '0;
            last_q   <= '0;
            fin_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // update together from the values present before the edge.
            state_q  <= state_d;
            len_q    <= len_d;
            depth_q  <= depth_d;
            dim_q    <= dim_d;
            bypass_q <= bypass_d;
            w_q      <= w_d;
            r_q      <= r_d;
            d_q      <= d_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            layers_q <= layers_d;
            vld_q    <= vld_d;
            first_q  <= first_d;
            last_q   <= last_d;
            fin_q    <= fin_d;
        end
    end

    assign ram_rd_addr_o    = addr_q;
    assign ker_valid_o      = vld_q[RD_LAT-1];
    assign ker_first_o      = first_q[RD_LAT-1];
    assign ker_last_o       = last_q[RD_LAT-1];
    assign done_o           = fin_q[RD_LAT-1];
    assign rd_layers_done_o = layers_q;
    assign busy_o           = (state_q == S_RUN) || (|vld_q);

endmodule

// File: tb/tb_exp_ker_rd_ctrl.sv
// Directed bench for exp_ker_rd_ctrl; two instances (RD_LAT 1 and 2) share stimulus.
module tb_exp_ker_rd_ctrl;
    localparam int ADDR_W  = 12;
    localparam int KW_W    = 7;
    localparam int DEPTH_W = 6;
    localparam int DIM_W   = 7;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               mode_3x3;
    logic               bypass;
    logic               req;
    logic [KW_W-1:0]    ker_words;
    logic [DEPTH_W-1:0] depth;
    logic [DIM_W-1:0]   dim;
    logic [DEPTH_W:0]   wr_cnt;

    logic              ready_1, rd_en_1, valid_1, first_1, last_1, busy_1, done_1;
    logic [ADDR_W-1:0] addr_1;
    logic [DEPTH_W:0]  layers_1;
    logic              ready_2, rd_en_2, valid_2, first_2, last_2, busy_2, done_2;
    logic [ADDR_W-1:0] addr_2;
    logic [DEPTH_W:0]  layers_2;

    exp_ker_rd_ctrl #(
        .ADDR_W(ADDR_W), .KW_W(KW_W), .DEPTH_W(DEPTH_W), .DIM_W(DIM_W), .RD_LAT(1)
    ) u_dut_lat1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_3x3_i(mode_3x3),
        .ker_words_i(ker_words), .depth_i(depth), .dim_i(dim), .bypass_i(bypass),
        .wr_layer_cnt_i(wr_cnt), .ker_req_i(req), .ker_ready_o(ready_1),
        .ram_rd_en_o(rd_en_1), .ram_rd_addr_o(addr_1), .ker_valid_o(valid_1),
        .ker_first_o(first_1), .ker_last_o(last_1), .rd_layers_done_o(layers_1),
        .busy_o(busy_1), .done_o(done_1)
    );

    exp_ker_rd_ctrl #(
        .ADDR_W(ADDR_W), .KW_W(KW_W), .DEPTH_W(DEPTH_W), .DIM_W(DIM_W), .RD_LAT(2)
    ) u_dut_lat2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_3x3_i(mode_3x3),
        .ker_words_i(ker_words), .depth_i(depth), .dim_i(dim), .bypass_i(bypass),
        .wr_layer_cnt_i(wr_cnt), .ker_req_i(req), .ker_ready_o(ready_2),
        .ram_rd_en_o(rd_en_2), .ram_rd_addr_o(addr_2), .ker_valid_o(valid_2),
        .ker_first_o(first_2), .ker_last_o(last_2), .rd_layers_done_o(layers_2),
        .busy_o(busy_2), .done_o(done_2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic start;
        logic req;
        logic ready;
        logic rd_en;
        int   addr;
        logic chk_addr;
        logic valid;
        logic first;
        logic last;
        logic done;
        int   layers;
        logic busy;
    } vec_t;

    vec_t tv [11];
    int   acc_idx [0:24];
    int   exp_seq [8] = '{0, 1, 0, 1, 2, 3, 2, 3};
    int   n_acc;
    int   k;
    logic exp_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic configure(input logic m, input int kw, input int dp, input int dm,
                             input logic bp);
        mode_3x3  = m;
        ker_words = KW_W'(kw);
        depth     = DEPTH_W'(dp);
        dim       = DIM_W'(dm);
        bypass    = bp;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready1"},  32'(ready_1),  0);
        check({tag, " rd_en1"},  32'(rd_en_1),  0);
        check({tag, " addr1"},   32'(addr_1),   0);
        check({tag, " valid1"},  32'(valid_1),  0);
        check({tag, " first1"},  32'(first_1),  0);
        check({tag, " last1"},   32'(last_1),   0);
        check({tag, " layers1"}, 32'(layers_1), 0);
        check({tag, " busy1"},   32'(busy_1),   0);
        check({tag, " done1"},   32'(done_1),   0);
        check({tag, " valid2"},  32'(valid_2),  0);
        check({tag, " busy2"},   32'(busy_2),   0);
        check({tag, " done2"},   32'(done_2),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        req    = 1'b0;
        wr_cnt = '0;
        configure(1'b0, 0, 0, 0, 1'b1);

        // Columns: start req | ready rd_en addr chk_addr | valid first last done | layers busy
        tv[0]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        tv[2]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
        tv[3]  = '{0, 1, 1, 1, 0, 1, 1, 0, 1, 0, 0, 1};
        tv[4]  = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
        tv[5]  = '{0, 1, 1, 1, 2, 1, 1, 0, 1, 0, 1, 1};
        tv[6]  = '{0, 1, 1, 1, 3, 1, 1, 1, 0, 0, 1, 1};
        tv[7]  = '{0, 1, 1, 1, 2, 1, 1, 0, 1, 0, 1, 1};
        tv[8]  = '{0, 1, 1, 1, 3, 1, 1, 1, 0, 0, 1, 1};
        tv[9]  = '{0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2, 1};
        tv[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1x1, kw=2, depth=1, dim=1, bypass, request held high.
        configure(1'b0, 2, 1, 1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = tv[i].start;
            req   = tv[i].req;
            #1;
            check($sformatf("t1[%0d] ready", i), 32'(ready_1), 32'(tv[i].ready));
            check($sformatf("t1[%0d] rd_en", i), 32'(rd_en_1), 32'(tv[i].rd_en));
            if (tv[i].chk_addr)
                check($sformatf("t1[%0d] addr", i), 32'(addr_1), tv[i].addr);
            check($sformatf("t1[%0d] valid", i), 32'(valid_1), 32'(tv[i].valid));
            if (tv[i].valid) begin
                check($sformatf("t1[%0d] first", i), 32'(first_1), 32'(tv[i].first));
                check($sformatf("t1[%0d] last", i), 32'(last_1), 32'(tv[i].last));
            end
            check($sformatf("t1[%0d] done", i), 32'(done_1), 32'(tv[i].done));
            check($sformatf("t1[%0d] layers", i), 32'(layers_1), tv[i].layers);
            check($sformatf("t1[%0d] busy", i), 32'(busy_1), 32'(tv[i].busy));
        end

        // 3x3, kw=1, depth=0, dim=0: addresses 0..8, last only on address 8.
        @(negedge clk);
        configure(1'b1, 1, 0, 0, 1'b1);
        start = 1'b1;
        req   = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (c <= 9) begin
                check($sformatf("t2[%0d] addr", c), 32'(addr_1), c - 1);
                check($sformatf("t2[%0d] rd_en", c), 32'(rd_en_1), 1);
            end else begin
                check($sformatf("t2[%0d] rd_en", c), 32'(rd_en_1), 0);
            end
            if (c >= 2) begin
                check($sformatf("t2[%0d] valid", c), 32'(valid_1), 1);
                check($sformatf("t2[%0d] last", c), 32'(last_1), (c == 10) ? 1 : 0);
            end
            check($sformatf("t2[%0d] done", c), 32'(done_1), (c == 10) ? 1 : 0);
        end
        @(negedge clk);
        req = 1'b0;

        // Write gating: bypass=0, slices released one at a time.
        @(negedge clk);
        configure(1'b0, 2, 1, 0, 1'b0);
        wr_cnt = '0;
        start  = 1'b1;
        req    = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("t3[%0d] ready gated", c), 32'(ready_1), 0);
            check($sformatf("t3[%0d] rd_en gated", c), 32'(rd_en_1), 0);
            check($sformatf("t3[%0d] busy", c), 32'(busy_1), 1);
        end
        @(negedge clk);
        wr_cnt = 1;
        #1;
        check("t3[4] ready same cycle", 32'(ready_1), 1);
        check("t3[4] addr", 32'(addr_1), 0);
        @(negedge clk);
        #1;
        check("t3[5] addr", 32'(addr_1), 1);
        @(negedge clk);
        #1;
        check("t3[6] ready slice1 gated", 32'(ready_1), 0);
        check("t3[6] addr", 32'(addr_1), 2);
        check("t3[6] layers", 32'(layers_1), 1);
        check("t3[6] last", 32'(last_1), 1);
        @(negedge clk);
        #1;
        check("t3[7] ready", 32'(ready_1), 0);
        check("t3[7] valid", 32'(valid_1), 0);
        @(negedge clk);
        wr_cnt = 2;
        #1;
        check("t3[8] ready", 32'(ready_1), 1);
        check("t3[8] addr", 32'(addr_1), 2);
        @(negedge clk);
        #1;
        check("t3[9] addr", 32'(addr_1), 3);
        @(negedge clk);
        req = 1'b0;
        #1;
        check("t3[10] done", 32'(done_1), 1);
        check("t3[10] layers", 32'(layers_1), 2);
        wr_cnt = '0;

        // Backpressure on the RD_LAT=2 instance: request every other cycle.
        for (int i = 0; i <= 24; i++) acc_idx[i] = -1;
        n_acc = 0;
        @(negedge clk);
        configure(1'b0, 2, 1, 1, 1'b1);
        start = 1'b1;
        req   = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            req   = (c % 2 == 1);
            #1;
            exp_rd = req && (n_acc < 8);
            check($sformatf("t4[%0d] rd_en", c), 32'(rd_en_2), 32'(exp_rd));
            if (exp_rd) begin
                check($sformatf("t4[%0d] addr", c), 32'(addr_2), exp_seq[n_acc]);
                acc_idx[c] = n_acc;
                n_acc++;
            end
            if (c >= 2 && acc_idx[c-2] >= 0) begin
                k = acc_idx[c-2];
                check($sformatf("t4[%0d] valid", c), 32'(valid_2), 1);
                check($sformatf("t4[%0d] first", c), 32'(first_2), (k % 2 == 0) ? 1 : 0);
                check($sformatf("t4[%0d] last", c), 32'(last_2), (k % 2 == 1) ? 1 : 0);
                check($sformatf("t4[%0d] done", c), 32'(done_2), (k == 7) ? 1 : 0);
            end else begin
                check($sformatf("t4[%0d] valid", c), 32'(valid_2), 0);
                check($sformatf("t4[%0d] done", c), 32'(done_2), 0);
            end
        end
        check("t4 busy after drain", 32'(busy_2), 0);
        check("t4 layers", 32'(layers_2), 2);

        // Restart after three accepts with kw=3.
        @(negedge clk);
        configure(1'b0, 2, 1, 1, 1'b1);
        start = 1'b1;
        req   = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("t5[%0d] addr", c), 32'(addr_1), exp_seq[c-1]);
        end
        @(negedge clk);
        configure(1'b0, 3, 1, 1, 1'b1);
        start = 1'b1;
        #1;
        check("t5[4] rd_en suppressed", 32'(rd_en_1), 0);
        check("t5[4] valid1", 32'(valid_1), 1);
        check("t5[4] valid2", 32'(valid_2), 1);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t5[5] addr", 32'(addr_1), 0);
        check("t5[5] layers", 32'(layers_1), 0);
        check("t5[5] valid1 cleared", 32'(valid_1), 0);
        check("t5[5] valid2 cleared", 32'(valid_2), 0);
        check("t5[5] rd_en", 32'(rd_en_1), 1);
        @(negedge clk);
        #1;
        check("t5[6] addr", 32'(addr_1), 1);
        check("t5[6] first1", 32'(first_1), 1);
        @(negedge clk);
        #1;
        check("t5[7] addr", 32'(addr_1), 2);
        check("t5[7] first2", 32'(first_2), 1);
        @(negedge clk);
        #1;
        check("t5[8] addr replay", 32'(addr_1), 0);
        check("t5[8] last1", 32'(last_1), 1);

        // Asynchronous reset between edges, mid-pass.
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("t6[%0d] ready", c), 32'(ready_1), 0);
            check($sformatf("t6[%0d] busy", c), 32'(busy_1), 0);
        end

        // start with kw=0 is ignored.
        @(negedge clk);
        configure(1'b0, 0, 0, 0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t7 kw0 busy", 32'(busy_1), 0);
        check("t7 kw0 ready", 32'(ready_1), 0);

        // Fresh single-word pass after reset.
        @(negedge clk);
        configure(1'b0, 1, 0, 0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t8 ready", 32'(ready_1), 1);
        check("t8 addr", 32'(addr_1), 0);
        check("t8 busy", 32'(busy_1), 1);
        @(negedge clk);
        #1;
        check("t8 valid", 32'(valid_1), 1);
        check("t8 first", 32'(first_1), 1);
        check("t8 last", 32'(last_1), 1);
        check("t8 done", 32'(done_1), 1);
        check("t8 ready after", 32'(ready_1), 0);
        req = 1'b0;

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
